// File: rtl/compressor_arbiter_pkg.sv
// Shared definitions for the compressor input arbiter and the Compressor-side modules.
package compressor_arbiter_pkg;

  localparam int unsigned DefDataWidth = 256;
  localparam int unsigned DefNumSrc    = 4;
  localparam int unsigned DefSrcIdW    = 2;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/compressor_arbiter_rr_pick.sv
// Combinational round-robin scan: first requester after last_grant, wrapping modulo NUM_SRC.
module compressor_arbiter_rr_pick #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned SRC_ID_W = 2
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [SRC_ID_W-1:0] last_grant,
  output logic                any_req,
  output logic [SRC_ID_W-1:0] pick_id
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    any_req = 1'b0;
    pick_id = '0;
    // last_grant itself is scanned last, so a lone requester can be re-granted
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = (32'(last_grant) + off) % NUM_SRC;
      if (!any_req && req[idx[SRC_ID_W-1:0]]) begin
        any_req = 1'b1;
        pick_id = idx[SRC_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/compressor_arbiter.sv
// Packet-granular round-robin arbiter feeding one Compressor from NUM_SRC stream sources.
// Optional per-source packet/beat counters under COMPRESSOR_ARBITER_STATS_EN.
module compressor_arbiter
  import compressor_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_SRC    = DefNumSrc,
  parameter int unsigned SRC_ID_W   = DefSrcIdW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wrt_en,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [SRC_ID_W-1:0]           grant_id,
  output logic                          busy
`ifdef COMPRESSOR_ARBITER_STATS_EN
  ,
  input  logic [SRC_ID_W-1:0]           stat_sel,
  output logic [31:0]                   stat_pkts,
  output logic [31:0]                   stat_beats
`endif
);

  arb_state_e          state_q, state_d;
  logic [SRC_ID_W-1:0] grant_q, grant_d;
  logic [SRC_ID_W-1:0] last_q, last_d;
  logic                any_req;
  logic [SRC_ID_W-1:0] pick_id;
  logic                xfer;

  compressor_arbiter_rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .SRC_ID_W (SRC_ID_W)
  ) u_rr_pick (
    .req        (s_tvalid),
    .last_grant (last_q),
    .any_req    (any_req),
    .pick_id    (pick_id)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    m_data   = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    case (state_q)
      StIdle: begin
        if (wrt_en && any_req) begin
          state_d = StBusy;
          grant_d = pick_id;
          last_d  = pick_id;
        end
      end
      StBusy: begin
        m_data            = s_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        m_tvalid          = s_tvalid[grant_q];
        m_tlast           = s_tlast[grant_q];
        s_tready[grant_q] = m_tready;
        if (m_tvalid && m_tready && m_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= SRC_ID_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign xfer     = (state_q == StBusy) && m_tvalid && m_tready;
  assign busy     = (state_q == StBusy);
  assign grant_id = grant_q;

`ifdef COMPRESSOR_ARBITER_STATS_EN
  logic [31:0] pkt_cnt_q  [NUM_SRC];
  logic [31:0] beat_cnt_q [NUM_SRC];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        pkt_cnt_q[i]  <= '0;
        beat_cnt_q[i] <= '0;
      end
      stat_pkts  <= '0;
      stat_beats <= '0;
    end else begin
      if (xfer) begin
        if (beat_cnt_q[grant_q] != '1) beat_cnt_q[grant_q] <= beat_cnt_q[grant_q] + 32'd1;
        if (m_tlast && (pkt_cnt_q[grant_q] != '1)) begin
          pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
        end
      end
      stat_pkts  <= pkt_cnt_q[stat_sel];
      stat_beats <= beat_cnt_q[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_compressor_arbiter.sv
// Scoreboard bench for compressor_arbiter: queued source models, decoupled output monitor.
module tb_compressor_arbiter;

  localparam int DW = 256;
  localparam int NS = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             wrt_en;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_data;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [IW-1:0]    grant_id;
  logic             busy;
`ifdef COMPRESSOR_ARBITER_STATS_EN
  logic [IW-1:0]    stat_sel;
  logic [31:0]      stat_pkts;
  logic [31:0]      stat_beats;
`endif

  beat_t src_q [NS][$];
  beat_t exp_q [NS][$];
  int    grant_exp [$];

  int checks   = 0;
  int passes   = 0;
  int cyc      = 0;
  int last_end = -1;
  int prev_cyc = 0;
  bit in_pkt   = 1'b0;
  bit chk_gap  = 1'b0;

  int bp_ready [6] = '{1, 0, 0, 1, 1, 1};
  int bp_idx   [6] = '{0, 1, 1, 1, 2, 3};

  always #5 clk = ~clk;

  compressor_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_SRC    (NS),
    .SRC_ID_W   (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wrt_en     (wrt_en),
    .s_data     (s_data),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_data     (m_data),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef COMPRESSOR_ARBITER_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_pkts  (stat_pkts),
    .stat_beats (stat_beats)
`endif
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] beat_data(input int src, input int pkt, input int beat);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(src << 16) | 32'(pkt << 8) | 32'(beat);
    return {8{w}};
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tlast[i]          = src_q[i][0].last;
        s_data[i*DW +: DW]  = src_q[i][0].data;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tlast[i]          = 1'b0;
        s_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic send_pkt(input int src, input int pkt, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = beat_data(src, pkt, k);
      b.last = (k == n - 1);
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (all_empty() && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", DW'(ok), DW'(1));
  endtask

  // Source models: handshake seen at negedge, beat retired just after the edge.
  initial begin
    logic [NS-1:0] xs;
    forever begin
      @(negedge clk);
      xs = s_tready & s_tvalid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (xs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      drive_srcs();
    end
  end

  // Output monitor / scoreboard.
  initial begin
    beat_t e;
    int    g;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        in_pkt = 1'b0;
      end else if (m_tvalid && m_tready) begin
        g = int'(grant_id);
        if (exp_q[g].size() == 0) begin
          check("unexpected_beat", DW'(1), DW'(0));
        end else begin
          e = exp_q[g].pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", DW'(m_tlast), DW'(e.last));
        end
        if (!in_pkt) begin
          if (grant_exp.size() > 0) check("grant_order", DW'(grant_id), DW'(grant_exp.pop_front()));
          if (chk_gap && last_end >= 0) check("idle_gap", DW'(cyc - last_end), DW'(2));
        end else if (chk_gap) begin
          check("contiguous", DW'(cyc - prev_cyc), DW'(1));
        end
        prev_cyc = cyc;
        in_pkt   = !m_tlast;
        if (m_tlast) last_end = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    wrt_en   = 1'b0;
    m_tready = 1'b0;
    s_data   = '0;
    s_tvalid = '0;
    s_tlast  = '0;
`ifdef COMPRESSOR_ARBITER_STATS_EN
    stat_sel = '0;
`endif
    drive_srcs();
    #12;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_grant", DW'(grant_id), DW'(0));
    check("rst_tvalid", DW'(m_tvalid), DW'(0));
    check("rst_tlast", DW'(m_tlast), DW'(0));
    check("rst_tready", DW'(s_tready), DW'(0));
    check("rst_data", m_data, DW'(0));
    tick();
    reset = 1'b1;

    // Single source, 3 beats
    tick();
    wrt_en   = 1'b1;
    m_tready = 1'b1;
    send_pkt(0, 1, 3);
    grant_exp.push_back(0);
    drive_srcs();
    @(negedge clk);
    check("t1_idle_busy", DW'(busy), DW'(0));
    check("t1_idle_tvalid", DW'(m_tvalid), DW'(0));
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check("t1_busy", DW'(busy), DW'(1));
      check("t1_grant", DW'(grant_id), DW'(0));
      check("t1_tvalid", DW'(m_tvalid), DW'(1));
      check("t1_tlast", DW'(m_tlast), DW'(b == 2));
    end
    @(negedge clk);
    check("t1_done_busy", DW'(busy), DW'(0));
    wait_done(50);

    // Backpressure on a 4-beat packet from source 2
    tick();
    send_pkt(2, 2, 4);
    grant_exp.push_back(2);
    drive_srcs();
    @(negedge clk);
    check("bp_idle", DW'(busy), DW'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      m_tready = bp_ready[k][0];
      @(negedge clk);
      check("bp_grant", DW'(grant_id), DW'(2));
      check("bp_tready", DW'(s_tready), bp_ready[k] != 0 ? DW'(4'b0100) : DW'(0));
      check("bp_data", m_data, beat_data(2, 2, bp_idx[k]));
      check("bp_tlast", DW'(m_tlast), DW'(bp_idx[k] == 3));
    end
    tick();
    m_tready = 1'b1;
    wait_done(50);

    // wrt_en dropped while source 1 is mid-packet and source 3 requests
    tick();
    send_pkt(1, 3, 3);
    grant_exp.push_back(1);
    drive_srcs();
    tick();
    wrt_en = 1'b0;
    send_pkt(3, 4, 2);
    grant_exp.push_back(3);
    drive_srcs();
    @(negedge clk);
    check("we_grant1", DW'(grant_id), DW'(1));
    check("we_busy1", DW'(busy), DW'(1));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("we_hold_busy", DW'(busy), DW'(0));
      check("we_hold_tready", DW'(s_tready), DW'(0));
    end
    tick();
    wrt_en = 1'b1;
    @(negedge clk);
    check("we_eval_idle", DW'(busy), DW'(0));
    @(negedge clk);
    check("we_busy3", DW'(busy), DW'(1));
    check("we_grant3", DW'(grant_id), DW'(3));
    wait_done(50);

    // Reset on beat 2 of a 5-beat packet from source 0
    tick();
    send_pkt(0, 5, 5);
    drive_srcs();
    @(negedge clk);
    @(negedge clk);
    check("rm_tvalid_pre", DW'(m_tvalid), DW'(1));
    tick();
    #1;
    reset = 1'b0;
    #1;
    check("rm_tvalid", DW'(m_tvalid), DW'(0));
    check("rm_tready", DW'(s_tready), DW'(0));
    check("rm_busy", DW'(busy), DW'(0));
    check("rm_grant", DW'(grant_id), DW'(0));
    src_q[0].delete();
    exp_q[0].delete();
    drive_srcs();
    tick();
    tick();
    reset = 1'b1;

    // Fairness from the reset pointer: all sources hold continuous 2-beat packets
    chk_gap  = 1'b1;
    last_end = -1;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < NS; s++) begin
        send_pkt(s, 10 + p * 4 + s, 2);
        grant_exp.push_back(s);
      end
    end
    drive_srcs();
    wait_done(100);
    chk_gap = 1'b0;

`ifdef COMPRESSOR_ARBITER_STATS_EN
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    send_pkt(1, 20, 3);
    send_pkt(1, 21, 3);
    grant_exp.push_back(1);
    grant_exp.push_back(1);
    drive_srcs();
    wait_done(50);
    tick();
    stat_sel = 2'd1;
    @(posedge clk);
    @(negedge clk);
    check("st_pkts1", DW'(stat_pkts), DW'(2));
    check("st_beats1", DW'(stat_beats), DW'(6));
    tick();
    stat_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check("st_pkts0", DW'(stat_pkts), DW'(0));
    check("st_beats0", DW'(stat_beats), DW'(0));
`endif

    check("grant_exp_left", DW'(grant_exp.size()), DW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/compressor_arbiter.md
Name: compressor_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one Compressor instance between NUM_SRC AXI-stream-style packet sources.
- Sits directly upstream of the Compressor data_in/tvalid/tlast/tready interface.
- Grant is held for a whole packet, from the first beat through the tlast beat, so packets never interleave.
- Reports the granted source index so the downstream path can tag the compressed output.

Parameters:
- DATA_WIDTH, 256: beat width in bits (32 bytes).
- NUM_SRC, 4: number of requesting sources, 2..8.
- SRC_ID_W, 2: width of the source index; must equal clog2(NUM_SRC).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wrt_en  in  1  arbitration enable; when low no new grant is issued.
- s_data  in  NUM_SRC*DATA_WIDTH  source beats; source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tlast  in  NUM_SRC  per-source last-beat flag.
- s_tready  out  NUM_SRC  per-source ready.
- m_data  out  DATA_WIDTH  beat to Compressor data_in.
- m_tvalid  out  1  to Compressor tvalid.
- m_tlast  out  1  to Compressor tlast.
- m_tready  in  1  Compressor tready.
- grant_id  out  SRC_ID_W  index of the currently granted source.
- busy  out  1  high while a packet is being forwarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, grant_id=0.
  - Round-robin pointer last_grant=NUM_SRC-1, so source 0 has first priority.
  - m_tvalid=0, m_tlast=0, s_tready=0; m_data is a don't-care but is driven to 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - Outputs m_tvalid=0 and s_tready=0.
  - If wrt_en=1 and any s_tvalid=1: choose the first asserted source scanning last_grant+1, +2, … modulo NUM_SRC.
  - Register the choice into grant_id and last_grant, set busy=1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, with g=grant_id (combinational pass-through):
  - m_data = s_data[g]; m_tvalid = s_tvalid[g]; m_tlast = s_tlast[g].
  - s_tready[g] = m_tready; all other s_tready = 0.
- Beat transfer occurs when m_tvalid & m_tready.
- A transfer with m_tlast=1 returns the FSM to IDLE and clears busy on the next edge.
- Latency:
  - Grant decision costs 1 cycle: the first beat can transfer in the cycle after s_tvalid is seen in IDLE.
  - Zero-cycle datapath in BUSY.
  - Minimum 1 idle cycle between back-to-back packets.
- Single-beat packet (tvalid & tlast on the first beat): BUSY for exactly 1 cycle if m_tready=1.
- Backpressure: m_tready=0 holds all outputs stable; the source must hold its beat (AXI rule). The arbiter adds no buffering.
- Granted source drops tvalid mid-packet: stay in BUSY, grant held, m_tvalid=0 (bubble).
- wrt_en deasserted in BUSY: the current packet completes normally; no new grant follows until wrt_en=1.
- Requester inputs changing in the same cycle as the tlast transfer are evaluated in the following IDLE cycle.
- Reset mid-packet: immediate return to the reset state. The partial packet is abandoned; the source is responsible for restarting it.
- Pointer wrap: last_grant=NUM_SRC-1 makes the scan start at 0.

Optional Feature:
- Macro: COMPRESSOR_ARBITER_STATS_EN.
- When defined, adds:
  - Input stat_sel [SRC_ID_W].
  - Output stat_pkts [32]: completed-packet count for the selected source.
  - Output stat_beats [32]: transferred-beat count for the selected source.
- Counter behaviour:
  - One counter pair per source, incremented on transfers.
  - Counters saturate at 32'hFFFFFFFF and are cleared by reset.
  - Outputs are registered: 1-cycle read latency.
- When undefined, these ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, BUSY=1'b1) and the default DATA_WIDTH/NUM_SRC constants reused by Compressor-side modules.
- One natural sub-module, rr_pick: combinational round-robin priority scan taking req[NUM_SRC] and last_grant, producing any_req and pick_id.

Test Plan:
- Single source: source 0 sends 3 beats (tlast on beat 3), m_tready=1.
  -> grant_id=0; beats appear on m_data on cycles 2-4; m_tlast only on beat 3; busy drops after beat 3.
- Fairness: sources 0-3 all hold tvalid with continuous 2-beat packets.
  -> grant order 0,1,2,3,0; each packet contiguous; exactly 1 idle cycle between packets.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-beat packet from source 2.
  -> m_data/m_tlast stable while m_tready=0; s_tready[2] mirrors m_tready; s_tready[0,1,3]=0 throughout.
- wrt_en: wrt_en=0 while source 1 is mid-packet and source 3 is requesting.
  -> source 1 packet finishes; no grant to source 3 until wrt_en=1, then grant_id=3.
- Reset: reset asserted on beat 2 of a 5-beat packet.
  -> m_tvalid=0, s_tready=0, busy=0 asynchronously; after release, source 0 wins first even if it was the last granted.
- Stats (COMPRESSOR_ARBITER_STATS_EN): two 3-beat packets from source 1, stat_sel=1.
  -> stat_pkts=2, stat_beats=6 one cycle after stat_sel is applied.
